freq_cnt_mch: RTL and testbench

- Multi-channel frequency/period counter. Single clock domain.
- CH asynchronous digital inputs are synchronised and rising-edge detected.
- Frequency mode: each channel counts edges inside a programmable gate.
- Period mode: each channel measures clock cycles between consecutive rising edges.
- Adds saturation/overflow flags and per-channel signal-presence detection. Sits in the housekeeping/DIO path, read through the system register bus.

---
 rtl/freq_cnt_mch.sv | 173 +++++++++++++++++
 tb/tb_freq_cnt_mch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_cnt_mch.sv
// Multi-channel frequency/period counter with saturation flags and per-channel
// signal-presence detection. Single clock domain, asynchronous inputs synchronised.
module freq_cnt_mch #(
  parameter int unsigned CH   = 4,
  parameter int unsigned CW   = 32,
  parameter int unsigned GW   = 32,
  parameter int unsigned SYNC = 2,
  parameter int unsigned DEAD = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [CH-1:0]    sig_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [GW-1:0]    gate_len_i,
  output logic [CH*CW-1:0] cnt_o,
  output logic [CH-1:0]    vld_o,
  output logic [CH-1:0]    ovf_o,
  output logic [CH-1:0]    alive_o,
  output logic             gate_o
);

  localparam int unsigned DW = ($clog2(DEAD + 1) < 3) ? 3 : $clog2(DEAD + 1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [DW-1:0] DMAX  = DW'(DEAD);
  localparam logic [DW-1:0] DLAST = DW'(DEAD - 1);

  logic [SYNC-1:0][CH-1:0] sync_q;
  logic [CH-1:0]           hist_q;
  logic [CH-1:0]           rise_c;

  logic          en_q;
  logic          mode_q;
  logic [GW-1:0] len_q;
  logic [GW-1:0] gcnt_q;
  logic          en_rise_c;
  logic          mode_eff_c;
  logic [GW-1:0] len_in_c;
  logic [GW-1:0] len_eff_c;
  logic [GW-1:0] gnext_c;
  logic          term_c;

  // Synchroniser chain plus history flop; keeps running while disabled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_i};
      hist_q <= sync_q[SYNC-1];
    end
  end

  assign rise_c = sync_q[SYNC-1] & ~hist_q;

  // The enabling cycle already counts, so it uses the live inputs directly
  always_comb begin
    en_rise_c  = en_i & ~en_q;
    len_in_c   = (gate_len_i == '0) ? GW'(1) : gate_len_i;
    len_eff_c  = en_rise_c ? len_in_c : len_q;
    mode_eff_c = en_rise_c ? mode_i : mode_q;
    gnext_c    = gcnt_q + GW'(1);
    term_c     = en_i && (gnext_c >= len_eff_c);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q   <= 1'b0;
      mode_q <= 1'b0;
      len_q  <= GW'(1);
      gcnt_q <= '0;
      gate_o <= 1'b0;
    end else begin
      en_q   <= en_i;
      gate_o <= term_c;
      if (en_rise_c) begin
        mode_q <= mode_i;
        len_q  <= len_in_c;
      end
      if (term_c && !mode_eff_c) len_q <= len_in_c;
      if (!en_i)       gcnt_q <= '0;
      else if (term_c) gcnt_q <= '0;
      else             gcnt_q <= gnext_c;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : ch_g
    logic [CW-1:0] acc_q, res_q;
    logic [DW-1:0] dead_q;
    logic          sat_q, armed_q, since_q, ever_q, vld_q, ovf_q, alive_q;
    logic          ev_c, acc_full_c, dead_up_c, dead_hit_c, ever_next_c;
    logic [CW-1:0] acc_inc_c, acc_sum_c;
    logic [DW-1:0] dead_next_c;

    always_comb begin
      ev_c        = rise_c[n];
      acc_full_c  = (acc_q == CMAX);
      acc_inc_c   = acc_full_c ? CMAX : acc_q + CW'(1);
      acc_sum_c   = ev_c ? acc_inc_c : acc_q;
      dead_up_c   = term_c && !ev_c && !since_q && (dead_q < DMAX);
      dead_hit_c  = dead_up_c && (dead_q == DLAST);
      dead_next_c = ev_c ? '0 : (dead_up_c ? dead_q + DW'(1) : dead_q);
      ever_next_c = ever_q | ev_c;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        acc_q   <= '0;
        res_q   <= '0;
        dead_q  <= '0;
        sat_q   <= 1'b0;
        armed_q <= 1'b0;
        since_q <= 1'b0;
        ever_q  <= 1'b0;
        vld_q   <= 1'b0;
        ovf_q   <= 1'b0;
        alive_q <= 1'b0;
      end else begin
        vld_q <= 1'b0;
        if (!en_i) begin
          acc_q   <= '0;
          sat_q   <= 1'b0;
          armed_q <= 1'b0;
          since_q <= 1'b0;
          ever_q  <= 1'b0;
          dead_q  <= '0;
        end else begin
          dead_q  <= dead_next_c;
          ever_q  <= ever_next_c;
          since_q <= term_c ? 1'b0 : (since_q | ev_c);
          alive_q <= (dead_next_c < DMAX) && ever_next_c;
          if (!mode_eff_c) begin
            // Frequency: an edge on the terminal cycle closes into this window
            if (term_c) begin
              res_q <= acc_sum_c;
              ovf_q <= sat_q | (ev_c & acc_full_c);
              vld_q <= 1'b1;
              acc_q <= '0;
              sat_q <= 1'b0;
            end else begin
              acc_q <= acc_sum_c;
              sat_q <= sat_q | (ev_c & acc_full_c);
            end
          end else if (ev_c) begin
            if (armed_q) begin
              res_q <= acc_q;
              ovf_q <= sat_q;
              vld_q <= 1'b1;
            end
            acc_q   <= CW'(1);
            sat_q   <= 1'b0;
            armed_q <= 1'b1;
          end else begin
            acc_q <= acc_inc_c;
            sat_q <= sat_q | acc_full_c;
            if (dead_hit_c) begin
              res_q   <= '0;
              ovf_q   <= 1'b0;
              vld_q   <= 1'b1;
              armed_q <= 1'b0;
            end
          end
        end
      end
    end

    assign cnt_o[n*CW +: CW] = res_q;
    assign vld_o[n]          = vld_q;
    assign ovf_o[n]          = ovf_q;
    assign alive_o[n]        = alive_q;
  end

endmodule

// File: tb/tb_freq_cnt_mch.sv
// Randomised bench for freq_cnt_mch against a window/interval based reference model.
module tb_freq_cnt_mch;

  localparam int CH = 4, CW = 8, GW = 32, SYNC = 2, DEAD = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [CH-1:0]    sig_i;
  logic             en_i, mode_i;
  logic [GW-1:0]    gate_len_i;
  logic [CH*CW-1:0] cnt_o;
  logic [CH-1:0]    vld_o, ovf_o, alive_o;
  logic             gate_o;

  freq_cnt_mch #(.CH(CH), .CW(CW), .GW(GW), .SYNC(SYNC), .DEAD(DEAD)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sig_i(sig_i), .en_i(en_i), .mode_i(mode_i),
    .gate_len_i(gate_len_i), .cnt_o(cnt_o), .vld_o(vld_o), .ovf_o(ovf_o),
    .alive_o(alive_o), .gate_o(gate_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, cyc = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Stimulus: per channel a pulse train of period per (0 = low, <0 = random toggling)
  int per [CH];
  int ph  [CH];
  logic [CH-1:0] sv;

  task automatic drive_sig();
    for (int c = 0; c < CH; c++) begin
      if (per[c] > 0) begin
        ph[c] = (ph[c] + 1) % per[c];
        sv[c] = (ph[c] < per[c] / 2);
      end else if (per[c] == 0) begin
        sv[c] = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        sv[c] = ~sv[c];
      end
    end
    sig_i = sv;
  endtask

  // Reference model: sampled input history, gate schedule, per-channel windows
  logic [CH-1:0] hq [SYNC+2];
  bit en_prev, mode_m;
  int len_m, next_term;
  int win [CH], last_act [CH], dead [CH];
  bit armed [CH], since [CH], ever [CH];
  int e_cnt [CH];
  bit e_vld [CH], e_ovf [CH], e_alive [CH];
  bit e_gate;

  task automatic clear_chan();
    for (int c = 0; c < CH; c++) begin
      win[c] = 0; last_act[c] = 0; dead[c] = 0;
      armed[c] = 0; since[c] = 0; ever[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] evs;
    bit rise, term;
    int d;
    if (!rstn_i) begin
      for (int k = 0; k < SYNC + 2; k++) hq[k] = '0;
      en_prev = 0; mode_m = 0; len_m = 1; next_term = 0; e_gate = 0;
      clear_chan();
      for (int c = 0; c < CH; c++) begin
        e_cnt[c] = 0; e_vld[c] = 0; e_ovf[c] = 0; e_alive[c] = 0;
      end
      return;
    end
    for (int k = SYNC + 1; k > 0; k--) hq[k] = hq[k-1];
    hq[0] = sig_i;
    evs = hq[SYNC] & ~hq[SYNC+1];
    e_gate = 0;
    for (int c = 0; c < CH; c++) e_vld[c] = 0;
    if (!en_i) begin
      en_prev = 0;
      clear_chan();
      return;
    end
    rise = !en_prev;
    en_prev = 1;
    if (rise) begin
      mode_m = mode_i;
      len_m = (gate_len_i == 0) ? 1 : int'(gate_len_i);
      next_term = cyc + len_m - 1;
    end
    term = (cyc == next_term);
    if (term) begin
      e_gate = 1;
      if (!mode_m) len_m = (gate_len_i == 0) ? 1 : int'(gate_len_i);
      next_term = cyc + len_m;
    end
    for (int c = 0; c < CH; c++) begin
      if (!mode_m) begin
        if (evs[c]) win[c]++;
        if (term) begin
          e_cnt[c] = (win[c] > MAXC) ? MAXC : win[c];
          e_ovf[c] = (win[c] > MAXC);
          e_vld[c] = 1;
          win[c] = 0;
        end
      end else if (evs[c]) begin
        if (armed[c]) begin
          d = cyc - last_act[c];
          e_cnt[c] = (d > MAXC) ? MAXC : d;
          e_ovf[c] = (d > MAXC);
          e_vld[c] = 1;
        end
        armed[c] = 1;
        last_act[c] = cyc;
      end
      if (term) begin
        if (!evs[c] && !since[c]) begin
          if (dead[c] < DEAD) begin
            dead[c]++;
            if (dead[c] == DEAD && mode_m) begin
              e_cnt[c] = 0; e_ovf[c] = 0; e_vld[c] = 1; armed[c] = 0;
            end
          end
        end else dead[c] = 0;
        since[c] = 0;
      end else if (evs[c]) begin
        dead[c] = 0;
        since[c] = 1;
      end
      if (evs[c]) ever[c] = 1;
      e_alive[c] = (dead[c] < DEAD) && ever[c];
    end
  endtask

  task automatic compare();
    logic [CH*CW-1:0] ec;
    logic [CH-1:0] ev, eo, ea;
    for (int c = 0; c < CH; c++) begin
      ec[c*CW +: CW] = CW'(e_cnt[c]);
      ev[c] = e_vld[c]; eo[c] = e_ovf[c]; ea[c] = e_alive[c];
    end
    check("cnt", 64'(cnt_o), 64'(ec));
    check("vld", 64'(vld_o), 64'(ev));
    check("ovf", 64'(ovf_o), 64'(eo));
    check("alive", 64'(alive_o), 64'(ea));
    check("gate", 64'(gate_o), 64'(e_gate));
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      cyc++;
      model_step();
      compare();
      drive_sig();
    end
  endtask

  initial begin
    rstn_i = 1'b1; en_i = 1'b0; mode_i = 1'b0; gate_len_i = '0; sig_i = '0; sv = '0;
    for (int c = 0; c < CH; c++) begin per[c] = 0; ph[c] = 0; end
    #1 rstn_i = 1'b0;
    run(3);
    rstn_i = 1'b1;
    run(5);

    // Frequency mode, L=1000, channel periods 10/40, two static channels
    gate_len_i = 1000; mode_i = 1'b0; per[0] = 10; per[1] = 40;
    en_i = 1'b1;
    run(3100);

    // Frequency mode, random rates and gate lengths re-latched at each terminal
    en_i = 1'b0; run(3);
    for (int c = 0; c < CH - 1; c++) per[c] = $urandom_range(2, 30);
    per[CH-1] = -1;
    gate_len_i = GW'($urandom_range(50, 200)); en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(100);
      gate_len_i = GW'($urandom_range(20, 120));
    end

    // Period mode: 37-cycle channel, random channels, one static
    en_i = 1'b0; run(3);
    mode_i = 1'b1; gate_len_i = GW'($urandom_range(100, 150));
    per[0] = 37; per[1] = $urandom_range(5, 60); per[2] = -1; per[3] = 0;
    en_i = 1'b1;
    run(800);

    // Saturation at 255 then an in-range interval
    per[0] = 300; run(1300);
    per[0] = 50;  run(300);

    // Dead detection, L=100: stop channel 0, then resume
    en_i = 1'b0; run(2);
    gate_len_i = 100; per[0] = 20; per[1] = 0; per[2] = 0; per[3] = 0;
    en_i = 1'b1;
    run(300);
    per[0] = 0;  run(700);
    per[0] = 25; run(200);

    // Control: mode change ignored while enabled, honoured at re-enable
    en_i = 1'b0; run(2);
    mode_i = 1'b0; gate_len_i = 150;
    for (int c = 0; c < CH; c++) per[c] = $urandom_range(4, 40);
    en_i = 1'b1;
    run(100);
    mode_i = 1'b1; run(120);
    en_i = 1'b0; gate_len_i = 90; run(50);
    en_i = 1'b1; run(100);
    gate_len_i = 30; run(300);

    // Asynchronous reset between clock edges, then gate length 0
    run(37);
    #3 rstn_i = 1'b0;
    #1;
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_vld", 64'(vld_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_alive", 64'(alive_o), 64'd0);
    check("rst_gate", 64'(gate_o), 64'd0);
    run(3);
    mode_i = 1'b0; gate_len_i = '0;
    rstn_i = 1'b1;
    run(40);
    en_i = 1'b0; run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
